// File: rtl/thermo16_pkg.sv
// Shared constants and stage records for the 16-bit thermometer decoder.
// WIDTH   : thermometer output width
// CNT_W   : width of the ones-count input
// STAGES  : register stages from accept to output
// MAX_CNT : largest count that is not saturated
package thermo16_pkg;

    localparam int WIDTH   = 16;
    localparam int CNT_W   = 5;
    localparam int STAGES  = 3;
    localparam int MAX_CNT = 16;
    localparam int HALF_W  = MAX_CNT / 2;

    // Stage 1: clamped count plus saturation flag.
    typedef struct packed {
        logic             valid;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } stage1_t;

    // Stage 2: the two independently decoded half-codes.
    typedef struct packed {
        logic              valid;
        logic [HALF_W-1:0] hi;
        logic [HALF_W-1:0] lo;
        logic              sat;
    } stage2_t;

endpackage

// File: rtl/thermo16_decoder_thermo8.sv
// Combinational 8-bit thermometer decoder for one half of the output.
// cnt  : ones-count for this half, 0..8
// en   : when 0 the code is forced to all zeros
// code : bit i is 1 exactly when en=1 and i < cnt
module thermo8_decode
    import thermo16_pkg::*;
(
    input  logic [3:0]        cnt,
    input  logic              en,
    output logic [HALF_W-1:0] code
);

    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < HALF_W; i++) begin
            code[i] = en && (i < 32'(cnt));
        end
    end

endmodule

// File: rtl/thermo16_decoder.sv
// Pipelined count-to-thermometer decoder with valid/ready handshaking.
// clk, rst            : rising-edge clock, synchronous active-high reset
// in_, in_valid       : ones-count to expand and its valid flag
// in_ready            : equals the pipeline advance signal
// out_, out_sat       : thermometer code and saturation flag
// out_valid, out_ready: output handshake
// xfer_cnt            : number of words delivered, modulo 256
module thermo16_decoder #(
    parameter int WIDTH  = thermo16_pkg::WIDTH,
    parameter int CNT_W  = thermo16_pkg::CNT_W,
    parameter int STAGES = thermo16_pkg::STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] in_,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       xfer_cnt
);

    import thermo16_pkg::*;

    // The stage split is hard-wired to two 8-bit halves over three registers.
    if (STAGES != 3 || WIDTH != 2 * HALF_W) begin : g_unsupported
        $error("thermo16_decoder supports only WIDTH=16 and STAGES=3");
    end

    logic    advance;
    stage1_t s1;
    stage2_t s2;

    logic             in_sat;
    logic [CNT_W-1:0] in_clamped;
    logic             hi_en;
    logic [CNT_W-1:0] hi_full;
    logic [3:0]       lo_cnt;
    logic [3:0]       hi_cnt;
    logic [HALF_W-1:0] lo_code;
    logic [HALF_W-1:0] hi_code;

    // All stages move in lockstep; bubbles are carried, not squeezed out.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    assign in_sat     = in_ > CNT_W'(WIDTH);
    assign in_clamped = in_sat ? CNT_W'(WIDTH) : in_;

    // Lower half saturates at 8; upper half sees the remainder above 8.
    assign hi_en   = s1.cnt > CNT_W'(HALF_W);
    assign hi_full = s1.cnt - CNT_W'(HALF_W);
    assign lo_cnt  = hi_en ? 4'(HALF_W) : s1.cnt[3:0];
    assign hi_cnt  = hi_en ? hi_full[3:0] : '0;

    thermo8_decode u_lo (
        .cnt  (lo_cnt),
        .en   (1'b1),
        .code (lo_code)
    );

    thermo8_decode u_hi (
        .cnt  (hi_cnt),
        .en   (hi_en),
        .code (hi_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            out_      <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1.valid  <= in_valid;
            s1.cnt    <= in_clamped;
            s1.sat    <= in_sat;
            s2.valid  <= s1.valid;
            s2.lo     <= lo_code;
            s2.hi     <= hi_code;
            s2.sat    <= s1.sat;
            out_      <= {s2.hi, s2.lo};
            out_sat   <= s2.sat;
            out_valid <= s2.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end

endmodule

// File: doc/thermo16_decoder.md
THERMO16_DECODER -- requirements
Module: thermo16_decoder

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the output vector width.
REQ-002 Parameter CNT_W, default 5, SHALL set the input count width, equal to clog2(WIDTH+1).
REQ-003 Parameter STAGES, default 3, SHALL set the pipeline depth from accept to output.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_  input  CNT_W  unsigned ones-count to expand.
REQ-008 in_valid  input  1  in_ holds a word.
REQ-009 in_ready  output  1  block accepts the word this cycle.
REQ-010 out_  output  WIDTH  thermometer code.
REQ-011 out_sat  output  1  input count exceeded WIDTH and was saturated.
REQ-012 out_valid  output  1  out_ and out_sat hold a word.
REQ-013 out_ready  input  1  downstream accepts the word this cycle.
REQ-014 xfer_cnt  output  8  count of words delivered downstream, modulo 256.

Function
REQ-015 For count c <= WIDTH, out_ bit i SHALL be 1 exactly when i < c, and out_sat SHALL be 0.
REQ-016 For c > WIDTH, out_ SHALL be all ones and out_sat SHALL be 1.
REQ-017 Each word that meets the acceptance condition SHALL appear on out_ exactly STAGES cycles later, provided no stall occurs in between.
REQ-018 The acceptance condition is in_valid & in_ready at a rising edge.
REQ-019 The delivery condition is out_valid & out_ready at a rising edge.
REQ-020 advance = ~out_valid | out_ready; all pipeline stages SHALL shift together only when advance is 1.
REQ-021 in_ready SHALL equal advance, combinationally; no other path from input to output is permitted.
REQ-022 A stage whose upstream holds no valid word SHALL load valid=0, so bubbles propagate; they are not collapsed.
REQ-023 When advance is 0, every stage SHALL hold its data and valid bit unchanged.
REQ-024 out_ and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Throughput SHALL be one word per cycle while out_ready is held at 1.
REQ-026 Pipeline split:
- stage 1 registers c and the saturation flag;
- stage 2 decodes the lower and upper 8-bit halves;
- stage 3 merges the halves and registers the outputs.
REQ-027 xfer_cnt SHALL increment by 1 on each delivery and wrap from 255 to 0.
REQ-028 Words SHALL be delivered in acceptance order, with none dropped or duplicated outside reset.

Reset
REQ-029 While rst=1 at a rising edge, these SHALL clear to 0 on that edge: all stage valid bits, all stage data, out_, out_sat, out_valid and xfer_cnt.
REQ-030 Assertion of rst mid-operation SHALL discard all in-flight words, and no partial word SHALL be emitted.
REQ-031 in_ready SHALL read 1 in the first cycle after reset, since out_valid=0 then.
REQ-032 The cycle after rst deasserts SHALL accept input normally.

Structure
REQ-033 Package thermo16_pkg SHALL hold WIDTH, CNT_W, STAGES and MAX_CNT=16, plus a stage-record typedef containing valid, count/half-codes and sat.
REQ-034 A single sub-module thermo8_decode SHALL be instantiated twice, once per half. It is combinational, with inputs 4-bit count and enable, and output 8-bit thermometer code.
REQ-035 The upper half SHALL be decoded with count c-8 when c>8, and as all zeros otherwise.

Verification
REQ-036 Reset, then in_=0, 8, 16 on consecutive cycles with out_ready=1 -> these words appear on cycles 3, 4 and 5 after the first accept:
- out_=0x0000, then 0x00FF, then 0xFFFF;
- out_sat=0 for all three.
REQ-037 in_=17 and in_=31 -> out_=0xFFFF with out_sat=1 for both.
REQ-038 Sweep c=0..16 with out_ready=1 -> out_=(1<<c)-1 for each c, and xfer_cnt ends at 17.
REQ-039 Stall: stream 5 words, hold out_ready=0 for 4 cycles once out_valid=1 ->
- in_ready=0 throughout the stall;
- out_ stays frozen;
- after release, all 5 words arrive in order, none lost.
REQ-040 Assert rst for 1 cycle with 3 words in flight -> out_valid=0 and xfer_cnt=0 the next cycle, and none of the 3 words ever appears.
REQ-041 Deliver 256 words -> xfer_cnt wraps to 0.
